// File: rtl/mat_vec_loader_pkg.sv
// rtl/mat_vec_loader_pkg.sv - shared states, default geometry and lane convention for the GF(256) loader
package mat_vec_loader_pkg;

  localparam int DEF_MAT_ROW_SIZE_BYTES = 8;
  localparam int DEF_MAT_COL_SIZE_BYTES = 8;
  localparam int DEF_VEC_SIZE_BYTES     = 8;
  localparam int DEF_N_GF               = 2;
  localparam int DEF_PROC_SIZE          = DEF_N_GF * 8;
  localparam int DEF_MAT_WORDS          = DEF_MAT_ROW_SIZE_BYTES * DEF_MAT_COL_SIZE_BYTES / DEF_N_GF;
  localparam int DEF_VEC_WORDS          = DEF_VEC_SIZE_BYTES / DEF_N_GF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MAT,
    S_LOAD_VEC,
    S_FLUSH,
    S_START,
    S_WAIT_MUL,
    S_DONE
  } state_t;

  // Lane 0 sits in the most significant byte; the multiplier slices words the same way.
  function automatic int lane_lsb(input int lane, input int proc_size);
    return proc_size - 8 * lane - 8;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mat_vec_loader_byte_packer.sv
// rtl/mat_vec_loader_byte_packer.sv - packs N_GF accepted bytes into one PROC_SIZE-bit word
module mat_vec_loader_byte_packer
  import mat_vec_loader_pkg::*;
#(
  parameter int N_GF      = DEF_N_GF,
  parameter int PROC_SIZE = N_GF * 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_accept,
  input  logic [7:0]           i_data,
  output logic [PROC_SIZE-1:0] o_word,
  output logic                 o_word_valid
);

  localparam int CNT_W = (N_GF > 1) ? $clog2(N_GF) : 1;

  logic [CNT_W-1:0]     byte_cnt;
  logic [PROC_SIZE-1:0] pack_q;
  logic                 last_byte;

  assign last_byte    = (byte_cnt == CNT_W'(N_GF - 1));
  assign o_word_valid = i_accept && last_byte;

  // The completed word includes the byte being accepted, so the write can issue next cycle.
  always_comb begin
    o_word = pack_q;
    for (int j = 0; j < N_GF; j++) begin
      if (byte_cnt == CNT_W'(j)) begin
        o_word[lane_lsb(j, PROC_SIZE) +: 8] = i_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt <= '0;
      pack_q   <= '0;
    end else if (i_clear) begin
      byte_cnt <= '0;
      pack_q   <= '0;
    end else if (i_accept) begin
      pack_q   <= o_word;
      byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mat_vec_loader.sv
// rtl/mat_vec_loader.sv - byte-stream front end filling matrix/vector memories and starting the GF(256) multiplier
module mat_vec_loader
  import mat_vec_loader_pkg::*;
#(
  parameter int MAT_ROW_SIZE_BYTES = DEF_MAT_ROW_SIZE_BYTES,
  parameter int MAT_COL_SIZE_BYTES = DEF_MAT_COL_SIZE_BYTES,
  parameter int VEC_SIZE_BYTES     = DEF_VEC_SIZE_BYTES,
  parameter int N_GF               = DEF_N_GF,
  parameter int PROC_SIZE          = N_GF * 8,
  parameter int MAT_WORDS          = MAT_ROW_SIZE_BYTES * MAT_COL_SIZE_BYTES / N_GF,
  parameter int VEC_WORDS          = VEC_SIZE_BYTES / N_GF,
  parameter int MAT_AW             = addr_width(MAT_WORDS),
  parameter int VEC_AW             = addr_width(VEC_WORDS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [MAT_AW-1:0]    o_mat_addr,
  output logic [PROC_SIZE-1:0] o_mat_data,
  output logic                 o_mat_wen,
  output logic [VEC_AW-1:0]    o_vec_addr,
  output logic [PROC_SIZE-1:0] o_vec_data,
  output logic                 o_vec_wen,
  output logic                 o_mul_start,
  input  logic                 i_mul_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CNT_W = (MAT_AW > VEC_AW) ? MAT_AW : VEC_AW;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     word_cnt;
  logic                 accept;
  logic [PROC_SIZE-1:0] pk_word;
  logic                 pk_word_valid;
  logic                 mat_last, vec_last;

  assign accept   = i_valid && o_ready;
  assign mat_last = pk_word_valid && (state_q == S_LOAD_MAT) && (word_cnt == CNT_W'(MAT_WORDS - 1));
  assign vec_last = pk_word_valid && (state_q == S_LOAD_VEC) && (word_cnt == CNT_W'(VEC_WORDS - 1));

  mat_vec_loader_byte_packer #(
    .N_GF      (N_GF),
    .PROC_SIZE (PROC_SIZE)
  ) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (state_q == S_IDLE),
    .i_accept     (accept),
    .i_data       (i_data),
    .o_word       (pk_word),
    .o_word_valid (pk_word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_mul_start = 1'b0;
    o_done      = 1'b0;
    o_busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_load) state_d = S_LOAD_MAT;
      end
      S_LOAD_MAT: begin
        o_ready = 1'b1;
        if (mat_last) state_d = S_LOAD_VEC;
      end
      S_LOAD_VEC: begin
        o_ready = 1'b1;
        if (vec_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_START;
      S_START: begin
        o_mul_start = 1'b1;
        state_d     = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        if (i_mul_done) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobes pulse for one cycle; address/data hold their last value in between.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_cnt   <= '0;
      o_mat_wen  <= 1'b0;
      o_mat_addr <= '0;
      o_mat_data <= '0;
      o_vec_wen  <= 1'b0;
      o_vec_addr <= '0;
      o_vec_data <= '0;
    end else begin
      o_mat_wen <= 1'b0;
      o_vec_wen <= 1'b0;
      case (state_q)
        S_IDLE: word_cnt <= '0;
        S_LOAD_MAT: begin
          if (pk_word_valid) begin
            o_mat_wen  <= 1'b1;
            o_mat_addr <= word_cnt[MAT_AW-1:0];
            o_mat_data <= pk_word;
            word_cnt   <= mat_last ? '0 : word_cnt + CNT_W'(1);
          end
        end
        S_LOAD_VEC: begin
          if (pk_word_valid) begin
            o_vec_wen  <= 1'b1;
            o_vec_addr <= word_cnt[VEC_AW-1:0];
            o_vec_data <= pk_word;
            word_cnt   <= vec_last ? '0 : word_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
